// File: rtl/weight_pingpong_shifter.sv
// weight_pingpong_shifter: two-bank ping-pong weight buffer feeding LANES
// systolic-array columns, DEPTH words per column per bank. One bank loads
// from the weight fetch path while the other drains into the array, in
// LIFO (REVERSE=1) or FIFO (REVERSE=0) order.
//
// Optional build macro WPS_SKEW_EN: when defined, lane i's valid/data are
// delayed by i cycles so the array sees a diagonal wavefront; out_last and
// busy follow the last lane. When undefined, all lanes are aligned.
//
// Load handshake: a word is taken on a rising edge where in_valid and
// in_ready are both 1; in_valid may rise at any time and in_data must be
// stable while in_valid is high; in_ready is a register and never depends
// combinationally on in_valid.
module weight_pingpong_shifter #(
  parameter int DATASIZE = 8,
  parameter int DEPTH    = 4,
  parameter int LANES    = 4,
  parameter int REVERSE  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATASIZE-1:0] in_data,
  input  logic                      start,
  output logic [LANES-1:0]          out_valid,
  output logic [LANES*DATASIZE-1:0] out_data,
  output logic                      out_last,
  output logic [1:0]                full_cnt,
  output logic                      busy
);

  localparam int CW = $clog2(DEPTH);
  localparam int W  = LANES * DATASIZE;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_state_e;

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_active_q, rd_active_d;
  logic          busy_q, busy_d;
  logic          in_ready_q, in_ready_d;

  logic [W-1:0]  mem_q [2][DEPTH];

  // Aligned (unskewed) beat computed each cycle; registered below.
  logic [LANES-1:0] beat_valid_d;
  logic [W-1:0]     beat_data_d;
  logic             beat_last_d;
  logic             last_out;

  logic          accept;
  logic          start_ok;
  logic [CW-1:0] rd_idx;

  assign accept   = in_valid && in_ready_q && !clear;
  assign start_ok = start && !busy_q && (bank_q[rd_ptr_q] == B_FULL) && !clear;

  // Next-state logic for bank FSMs, pointers, counters and the aligned beat.
  always_comb begin
    bank_d[0]    = bank_q[0];
    bank_d[1]    = bank_q[1];
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    rd_active_d  = rd_active_q;
    busy_d       = busy_q;
    beat_valid_d = '0;
    beat_data_d  = '0;
    beat_last_d  = 1'b0;
    rd_idx       = rd_cnt_q;

    if (REVERSE != 0) begin
      rd_idx = LAST_IDX - rd_cnt_q;
    end

    if (accept) begin
      wr_cnt_d         = wr_cnt_q + CW'(1);
      bank_d[wr_ptr_q] = B_FILLING;
      if (wr_cnt_q == LAST_IDX) begin
        wr_cnt_d         = '0;
        bank_d[wr_ptr_q] = B_FULL;
        wr_ptr_d         = ~wr_ptr_q;
      end
    end

    if (rd_active_q) begin
      beat_valid_d = '1;
      beat_data_d  = mem_q[rd_ptr_q][rd_idx];
      rd_cnt_d     = rd_cnt_q + CW'(1);
      if (rd_cnt_q == LAST_IDX) begin
        beat_last_d      = 1'b1;
        rd_active_d      = 1'b0;
        rd_cnt_d         = '0;
        bank_d[rd_ptr_q] = B_EMPTY;
        rd_ptr_d         = ~rd_ptr_q;
      end
    end

    // busy covers the read beats plus any skew tail; it drops the cycle
    // after out_last.
    if (start_ok) begin
      bank_d[rd_ptr_q] = B_DRAINING;
      rd_active_d      = 1'b1;
      rd_cnt_d         = '0;
      busy_d           = 1'b1;
    end else if (last_out) begin
      busy_d = 1'b0;
    end

    // Uses the current bank state, so a bank freed on an edge only shows
    // ready one cycle later, while a bank that just filled is never
    // offered again because wr_ptr has already moved off it.
    in_ready_d = (bank_q[wr_ptr_d] == B_EMPTY) || (bank_q[wr_ptr_d] == B_FILLING);

    if (clear) begin
      bank_d[0]    = B_EMPTY;
      bank_d[1]    = B_EMPTY;
      wr_ptr_d     = 1'b0;
      rd_ptr_d     = 1'b0;
      wr_cnt_d     = '0;
      rd_cnt_d     = '0;
      rd_active_d  = 1'b0;
      busy_d       = 1'b0;
      in_ready_d   = 1'b1;
      beat_valid_d = '0;
      beat_data_d  = '0;
      beat_last_d  = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]   <= B_EMPTY;
      bank_q[1]   <= B_EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_active_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_active_q <= rd_active_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Weight storage; contents are don't-care after reset or clear.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q][wr_cnt_q] <= in_data;
    end
  end

`ifdef WPS_SKEW_EN
  logic [LANES-1:0] last_pipe_q;

  // out_last travels with the slowest lane (LANES-1 extra cycles).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pipe_q <= '0;
    end else if (clear) begin
      last_pipe_q <= '0;
    end else begin
      last_pipe_q[0] <= beat_last_d;
      for (int k = 1; k < LANES; k++) begin
        last_pipe_q[k] <= last_pipe_q[k-1];
      end
    end
  end

  assign last_out = last_pipe_q[LANES-1];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [i:0]          v_q;
    logic [DATASIZE-1:0] d_q [i+1];

    // Lane i chain: stage 0 is the aligned beat, stage i drives the port.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) begin
          v_q[k] <= 1'b0;
          d_q[k] <= '0;
        end
      end else if (clear) begin
        for (int k = 0; k <= i; k++) begin
          v_q[k] <= 1'b0;
          d_q[k] <= '0;
        end
      end else begin
        v_q[0] <= beat_valid_d[i];
        d_q[0] <= beat_data_d[i*DATASIZE +: DATASIZE];
        for (int k = 1; k <= i; k++) begin
          v_q[k] <= v_q[k-1];
          d_q[k] <= d_q[k-1];
        end
      end
    end

    assign out_valid[i]                     = v_q[i];
    assign out_data[i*DATASIZE +: DATASIZE] = d_q[i];
  end
`else
  logic [LANES-1:0] beat_valid_q;
  logic [W-1:0]     beat_data_q;
  logic             beat_last_q;

  // Aligned output register: every lane beats on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_valid_q <= '0;
      beat_data_q  <= '0;
      beat_last_q  <= 1'b0;
    end else begin
      beat_valid_q <= beat_valid_d;
      beat_data_q  <= beat_data_d;
      beat_last_q  <= beat_last_d;
    end
  end

  assign last_out  = beat_last_q;
  assign out_valid = beat_valid_q;
  assign out_data  = beat_data_q;
`endif

  assign out_last = last_out;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign full_cnt = {1'b0, bank_q[0] == B_FULL} + {1'b0, bank_q[1] == B_FULL};

endmodule

// File: doc/weight_pingpong_shifter.md
Name: weight_pingpong_shifter

Overview:
- Parametrised successor to the single-column weight shift register.
- Feeds LANES columns of the systolic array in parallel, DEPTH words per column.
- Two banks (ping-pong): one bank loads from the weight fetch path under a valid/ready handshake while the other drains into the array.
- Drain order is selectable: LIFO (the existing array convention) or FIFO.

Parameters:
DATASIZE, 8, bits per weight word
DEPTH, 4, words per lane per bank (array height); must be >= 2
LANES, 4, parallel columns served; must be >= 1
REVERSE, 1, 1 = drain last-loaded word first (LIFO); 0 = first-loaded first (FIFO)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
clear  in  1  synchronous flush of both banks and all counters
in_valid  in  1  in_data holds a word for every lane
in_ready  out  1  write bank can accept a word
in_data  in  LANES*DATASIZE  lane i at bits [i*DATASIZE +: DATASIZE]
start  in  1  single-cycle request to drain the oldest full bank
out_valid  out  LANES  per-lane beat valid
out_data  out  LANES*DATASIZE  per-lane weight; zero in any lane whose out_valid bit is low
out_last  out  1  final beat of the drain on lane LANES-1
full_cnt  out  2  number of FULL banks (0..2)
busy  out  1  drain in progress, including any skew tail

Behaviour:
- Reset (async) or clear (sync): both banks EMPTY; wr_ptr=rd_ptr=0; counters 0.
  - All outputs 0 except in_ready, which is 1.
  - Bank contents are don't-care.
  - clear has priority over every other input in the same cycle.
  - Reset or clear mid-drain aborts the drain; no further out_valid.
- Bank states: EMPTY -> FILLING (first accepted word) -> FULL (DEPTH-th accepted word) -> DRAINING (start accepted) -> EMPTY (final read beat).
- Load:
  - in_ready = 1 when bank[wr_ptr] is EMPTY or FILLING.
  - A word is accepted when in_valid && in_ready. It is written at index wr_cnt, then wr_cnt increments.
  - When wr_cnt reaches DEPTH-1 and a word is accepted: bank becomes FULL, wr_cnt wraps to 0, wr_ptr toggles.
  - in_ready is registered: while both banks are FULL or DRAINING, in_ready = 0 and in_valid is ignored.
- Drain:
  - start is accepted when busy = 0 and bank[rd_ptr] is FULL. Otherwise it is ignored, with no queueing and no error.
  - A start accepted at edge T: bank becomes DRAINING and busy rises.
  - Beats on cycles T+1 .. T+DEPTH, one word per cycle.
  - REVERSE=1: read index DEPTH-1 down to 0. REVERSE=0: read index 0 up to DEPTH-1.
  - After the final read beat: bank becomes EMPTY and rd_ptr toggles.
  - busy falls in the cycle after the last out_valid beat.
- full_cnt counts banks in FULL only. A bank that becomes FULL at edge T is startable from edge T+1; a start sampled at edge T is ignored.
- Concurrency: loading bank A while bank B drains is legal, with no bubbles on either side.
- A bank freed at edge T shows in_ready = 1 from T+1.
- Load data is never readable before its bank is FULL.
- Outputs out_valid, out_data and out_last are registered.

Optional Feature:
WPS_SKEW_EN
- Defined: lane i's out_valid and out_data are delayed by i extra cycles through per-lane register chains.
  - This gives the diagonal wavefront the array expects.
  - Lane i's beats occur on T+1+i .. T+DEPTH+i.
  - out_last coincides with lane LANES-1's final beat, at T+DEPTH+LANES-1.
  - busy stays high through that tail. Bank release timing is unchanged (final read beat).
- Undefined: all lanes are aligned. out_valid is all-ones or all-zeros, and out_last is at T+DEPTH.

Test Plan:
- DEPTH=4, LANES=4, REVERSE=1:
  - Load lane0 words 1,2,3,4 (other lanes +0x10 per lane), then start.
  - Expect lane0 out_data = 4,3,2,1 on T+1..T+4, lane3 = 0x34,0x33,0x32,0x31.
  - out_last at T+4; full_cnt 1->0.
- REVERSE=0, same load: expect lane0 = 1,2,3,4. Between beats and after drain, out_data = 0.
- Ping-pong and back-pressure:
  - Fill bank0, then drain it while streaming bank1's 4 words concurrently.
  - Expect no in_ready drop; bank1 is startable at the first edge after busy falls.
  - Fill both banks, then hold in_valid: expect in_ready = 0 and full_cnt = 2.
- Ignored starts:
  - Start with full_cnt = 0 -> no out_valid.
  - Start during busy -> no effect.
  - Start in the same edge as the 4th accepted word -> ignored; start next cycle -> accepted.
- Abort:
  - Assert rst asynchronously mid-clock at beat 2 -> out_valid = 0 and in_ready = 1 immediately; full_cnt = 0.
  - Repeat with clear: same response, taken at the next edge.
- WPS_SKEW_EN defined, LANES=4, DEPTH=4, start at T:
  - Lane i valid on T+1+i..T+4+i.
  - out_last at T+7; busy falls at T+8.
  - Bank in_ready returns at T+5.
